operand_b_stage: RTL and testbench

OPERAND_B_STAGE -- requirements
Module: operand_b_stage

---
 rtl/operand_b_stage_pkg.sv | 15 +
 rtl/operand_b_stage_sel.sv | 25 ++
 rtl/operand_b_stage.sv | 97 +++++++++
 tb/tb_operand_b_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/operand_b_stage_pkg.sv
// Shared constants for the operand-B select stage: source indices and default width.
package operand_b_stage_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam int SRC_RT    = 0;
  localparam int SRC_SEXT  = 1;
  localparam int SRC_ZEXT  = 2;
  localparam int SRC_SHAMT = 3;

  function automatic int sel_width(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/operand_b_stage_sel.sv
// Combinational source mux; out-of-range select yields zero data and raises err.
// Zero latency, no flow control of its own.
module operand_sel #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src,
  output logic [WIDTH-1:0]      dat,
  output logic                  err
);

  always_comb begin
    dat = '0;
    err = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        dat = src[k*WIDTH +: WIDTH];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_b_stage.sv
// Operand-B select stage with a two-entry skid buffer; 1-cycle latency when not full.
// in_ready is registered (low only when the skid entry is occupied), never derived from out_ready.
module operand_b_stage
  import operand_b_stage_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NSRC  = 4,
  localparam int SELW  = sel_width(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       in_sel,
  input  logic [NSRC*WIDTH-1:0] in_src,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  output logic                  sel_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       st;
  logic [WIDTH-1:0] main_dat, skid_dat, new_dat;
  logic [SELW-1:0]  main_sel, skid_sel;
  logic             new_err, err_q;
  logic             in_xfer, out_xfer;

  operand_sel #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_sel (
    .sel (in_sel),
    .src (in_src),
    .dat (new_dat),
    .err (new_err)
  );

  assign in_ready  = (st != FULL);
  assign out_valid = (st != EMPTY);
  assign out_data  = main_dat;
  assign out_sel   = main_sel;
  assign sel_err   = err_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Main is cleared whenever it empties so outputs read zero while invalid.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      st       <= EMPTY;
      main_dat <= '0;
      main_sel <= '0;
      skid_dat <= '0;
      skid_sel <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= in_xfer && new_err;
      case (st)
        EMPTY: begin
          if (in_xfer) begin
            main_dat <= new_dat;
            main_sel <= in_sel;
            st       <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_dat <= new_dat;
            main_sel <= in_sel;
          end else if (in_xfer) begin
            skid_dat <= new_dat;
            skid_sel <= in_sel;
            st       <= FULL;
          end else if (out_xfer) begin
            main_dat <= '0;
            main_sel <= '0;
            st       <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_dat <= skid_dat;
            main_sel <= skid_sel;
            skid_dat <= '0;
            skid_sel <= '0;
            st       <= ONE;
          end
        end
        default: st <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_b_stage.sv
// Directed bench for operand_b_stage: default instance (NSRC=4) plus an NSRC=5 instance
// whose 3-bit select can express an out-of-range index.
module tb_operand_b_stage;
  import operand_b_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
  logic [1:0]    a_in_sel, a_out_sel;
  logic [127:0]  a_src;
  logic [31:0]   a_out_data;

  logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
  logic [2:0]    b_in_sel, b_out_sel;
  logic [159:0]  b_src;
  logic [31:0]   b_out_data;

  int vectors = 0;
  int miscompares = 0;

  operand_b_stage #(.WIDTH(32), .NSRC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_src(a_src), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_sel(a_out_sel), .sel_err(a_sel_err)
  );

  operand_b_stage #(.WIDTH(32), .NSRC(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_src(b_src), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_sel(b_out_sel), .sel_err(b_sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic [1:0] sel, input logic [31:0] dat);
    a_in_valid = 1'b1;
    a_in_sel   = sel;
    a_src[sel*32 +: 32] = dat;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sel = '0; a_src = '0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sel = '0; b_src = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_out_data",  a_out_data,       32'd0);
    chk("rst_out_sel",   32'(a_out_sel),   32'd0);
    chk("rst_sel_err",   32'(a_sel_err),   32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Single transfer, sign-extended source
    offer_a(2'(SRC_SEXT), 32'hFFFF_FFFC);
    a_out_ready = 1'b1;
    tick();
    chk("lat_out_valid", 32'(a_out_valid), 32'd1);
    chk("lat_out_data",  a_out_data,       32'hFFFF_FFFC);
    chk("lat_out_sel",   32'(a_out_sel),   32'd1);
    a_in_valid = 1'b0;
    tick();
    chk("drain_out_valid", 32'(a_out_valid), 32'd0);
    chk("drain_out_data",  a_out_data,       32'd0);

    // Fill both entries, stall, then drain in order
    a_out_ready = 1'b0;
    offer_a(2'(SRC_RT), 32'h11);
    tick();
    offer_a(2'(SRC_ZEXT), 32'h22);
    tick();
    chk("full_in_ready", 32'(a_in_ready), 32'd0);
    chk("full_out_data", a_out_data,      32'h11);
    offer_a(2'(SRC_SHAMT), 32'h33);
    tick();
    chk("full_hold_data", a_out_data,      32'h11);
    chk("full_hold_sel",  32'(a_out_sel),  32'd0);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("order2_data",     a_out_data,      32'h22);
    chk("order2_sel",      32'(a_out_sel),  32'd2);
    chk("order2_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("order_empty", 32'(a_out_valid), 32'd0);

    // Flush from FULL with an input offered
    a_out_ready = 1'b0;
    offer_a(2'(SRC_RT), 32'h11);
    tick();
    offer_a(2'(SRC_ZEXT), 32'h22);
    tick();
    chk("fl_full_in_ready", 32'(a_in_ready), 32'd0);
    a_flush = 1'b1;
    tick();
    chk("fl_out_valid", 32'(a_out_valid), 32'd0);
    chk("fl_in_ready",  32'(a_in_ready),  32'd1);
    chk("fl_out_data",  a_out_data,       32'd0);
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("fl_no_emit", 32'(a_out_valid), 32'd0);

    // Flush beats simultaneous input and output transfers
    offer_a(2'(SRC_RT), 32'h55);
    tick();
    chk("fl2_pre_data", a_out_data, 32'h55);
    offer_a(2'(SRC_RT), 32'h66);
    a_flush = 1'b1;
    tick();
    chk("fl2_out_valid", 32'(a_out_valid), 32'd0);
    chk("fl2_in_ready",  32'(a_in_ready),  32'd1);
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk("fl2_dropped", 32'(a_out_valid), 32'd0);

    // Out-of-range select on the NSRC=5 instance
    b_in_valid = 1'b1;
    b_in_sel = 3'd5;
    b_src = {5{32'hA5A5_A5A5}};
    tick();
    chk("err_out_valid", 32'(b_out_valid), 32'd1);
    chk("err_out_data",  b_out_data,       32'd0);
    chk("err_out_sel",   32'(b_out_sel),   32'd5);
    chk("err_pulse",     32'(b_sel_err),   32'd1);
    b_in_sel = 3'd4;
    b_src[4*32 +: 32] = 32'h44;
    tick();
    chk("err_clear",     32'(b_sel_err),   32'd0);
    chk("err_next_data", b_out_data,       32'h44);
    b_in_valid = 1'b0;
    tick();
    chk("err_idle", 32'(b_sel_err), 32'd0);

    // Reset with both entries held
    a_out_ready = 1'b0;
    offer_a(2'(SRC_RT), 32'h77);
    tick();
    offer_a(2'(SRC_ZEXT), 32'h88);
    tick();
    chk("rst2_full", 32'(a_in_ready), 32'd0);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst2_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst2_out_data",  a_out_data,       32'd0);
    chk("rst2_in_ready",  32'(a_in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Streaming: one operand per cycle, in order, no gaps
    a_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      offer_a(2'(SRC_SHAMT), 32'h1000 + 32'(i));
      tick();
      chk("stream_valid", 32'(a_out_valid), 32'd1);
      chk("stream_data",  a_out_data,       32'h1000 + 32'(i));
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_end", 32'(a_out_valid), 32'd0);
    chk("stream_no_err", 32'(a_sel_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
